// File: rtl/bemf_pkg.sv
// Shared types and constants for the back-EMF sequencer and its update datapath.
// Also holds the helpers that read and write one motor's slice of an 80-bit bus.
package bemf_pkg;

  localparam int BEMF_W = 20;
  localparam int ADC_W  = 10;
  localparam int N_MOT  = 4;
  localparam int MOT_W  = $clog2(N_MOT);

  localparam logic ADC_SIDE_H = 1'b0;
  localparam logic ADC_SIDE_L = 1'b1;

  typedef logic [MOT_W-1:0]                mot_t;
  typedef logic signed [BEMF_W-1:0]        bemf_t;
  typedef logic [N_MOT-1:0][BEMF_W-1:0]    mot_bus_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_H,
    S_WAIT_H,
    S_CONV_L,
    S_WAIT_L,
    S_ISSUE,
    S_WAIT_RES,
    S_NEXT
  } state_t;

  function automatic bemf_t get_mot(input mot_bus_t bus, input mot_t m);
    return bus[m];
  endfunction

  function automatic mot_bus_t set_mot(input mot_bus_t bus, input mot_t m, input bemf_t v);
    mot_bus_t r;
    r    = bus;
    r[m] = v;
    return r;
  endfunction

endpackage

// File: rtl/bemf_sched_if.sv
// ADC front-end handshake between the sequencer (master) and the converter (slave).
interface bemf_sched_if;
  import bemf_pkg::*;

  logic             adc_start;
  logic [2:0]       adc_chan;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;

  modport master (output adc_start, output adc_chan, input adc_done, input adc_data);
  modport slave  (input adc_start, input adc_chan, output adc_done, output adc_data);
endinterface

// File: rtl/bemf_update.sv
// Four-stage back-EMF update: velocity = (h - l - calib) with a small deadband,
// position = bemf_in + velocity. Motor select travels with the data.
module bemf_update
  import bemf_pkg::*;
#(
  parameter int DATA_W = BEMF_W,
  parameter int COEF_W = BEMF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADC_W-1:0]         bemf_adc_h,
  input  logic [ADC_W-1:0]         bemf_adc_l,
  input  mot_t                     mot_sel_in,
  input  logic signed [DATA_W-1:0] bemf_in,
  input  logic signed [COEF_W-1:0] bemf_calib_in,
  output logic                     out_valid,
  output mot_t                     mot_sel_out,
  output logic signed [DATA_W-1:0] bemf_out,
  output logic signed [DATA_W-1:0] bemf_vel_out
);

  localparam logic signed [DATA_W-1:0] DEADBAND = DATA_W'(16);

  function automatic logic signed [DATA_W-1:0] adc_ext(input logic [ADC_W-1:0] a);
    return signed'(DATA_W'(a));
  endfunction

  function automatic logic signed [DATA_W-1:0] coef_ext(input logic signed [COEF_W-1:0] c);
    return DATA_W'(c);
  endfunction

  // Small differences are treated as noise and reported as zero velocity.
  function automatic logic signed [DATA_W-1:0] deadband(input logic signed [DATA_W-1:0] v);
    if ((v < DEADBAND) && (v > -DEADBAND)) return '0;
    return v;
  endfunction

  logic                     vld_p0, vld_p1, vld_p2, vld_p3;
  mot_t                     mot_p0, mot_p1, mot_p2, mot_p3;
  logic [ADC_W-1:0]         h_p0, l_p0;
  logic signed [COEF_W-1:0] cal_p0;
  logic signed [DATA_W-1:0] pos_p0, pos_p1, pos_p2, pos_p3;
  logic signed [DATA_W-1:0] diff_p1, vel_p2, vel_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    // p0: capture operands
    h_p0    <= bemf_adc_h;
    l_p0    <= bemf_adc_l;
    cal_p0  <= bemf_calib_in;
    pos_p0  <= bemf_in;
    mot_p0  <= mot_sel_in;
    // p1: calibrated difference
    diff_p1 <= adc_ext(h_p0) - adc_ext(l_p0) - coef_ext(cal_p0);
    pos_p1  <= pos_p0;
    mot_p1  <= mot_p0;
    // p2: deadband
    vel_p2  <= deadband(diff_p1);
    pos_p2  <= pos_p1;
    mot_p2  <= mot_p1;
    // p3: accumulate (wraps)
    pos_p3  <= pos_p2 + vel_p2;
    vel_p3  <= vel_p2;
    mot_p3  <= mot_p2;
  end

  assign out_valid    = vld_p3;
  assign mot_sel_out  = mot_p3;
  assign bemf_out     = pos_p3;
  assign bemf_vel_out = vel_p3;

endmodule

// File: rtl/bemf_sched.sv
// Back-EMF sweep sequencer: per period, measures motors 0-3 through the shared ADC,
// runs each through bemf_update and keeps the resulting position/velocity per motor.
module bemf_sched
  import bemf_pkg::*;
#(
  parameter int PERIOD      = 20000,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  bemf_sched_if.master            adc,
  input  logic [N_MOT*BEMF_W-1:0] bemf_calib,
  input  logic [N_MOT-1:0]        bemf_clr,
  output logic [N_MOT*BEMF_W-1:0] bemf_pos,
  output logic [N_MOT*BEMF_W-1:0] bemf_vel,
  output logic                    sweep_done,
  output logic [N_MOT-1:0]        adc_err,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ADC_TIMEOUT - 1);
  localparam mot_t             MOT_LAST = mot_t'(N_MOT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [TO_W-1:0]  to_cnt;
  mot_t             mot;
  logic             discard;
  logic [ADC_W-1:0] h_r, l_r;
  mot_bus_t         pos_r, vel_r;

  logic  tick, waiting, timeout, wb;
  logic  start_c, side_c, issue_c;
  logic  bu_out_valid;
  mot_t  bu_mot;
  bemf_t bu_pos, bu_vel, cur_pos, cur_cal;

  assign tick    = (per_cnt == PER_LAST);
  assign waiting = (state == S_WAIT_H) || (state == S_WAIT_L);
  assign timeout = waiting && !adc.adc_done && (to_cnt == TO_LAST);
  // A clear of the in-flight motor must not be undone by its stale result.
  assign wb      = (state == S_WAIT_RES) && bu_out_valid && !discard;

  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    side_c     = ADC_SIDE_H;
    issue_c    = 1'b0;
    sweep_done = 1'b0;
    overrun    = tick && (state != S_IDLE);
    unique case (state)
      S_IDLE:     if (tick && enable) state_nxt = S_CONV_H;
      S_CONV_H: begin
        start_c   = 1'b1;
        state_nxt = S_WAIT_H;
      end
      S_WAIT_H: begin
        if (adc.adc_done)  state_nxt = S_CONV_L;
        else if (timeout)  state_nxt = S_NEXT;
      end
      S_CONV_L: begin
        start_c   = 1'b1;
        side_c    = ADC_SIDE_L;
        state_nxt = S_WAIT_L;
      end
      S_WAIT_L: begin
        side_c = ADC_SIDE_L;
        if (adc.adc_done)  state_nxt = S_ISSUE;
        else if (timeout)  state_nxt = S_NEXT;
      end
      S_ISSUE: begin
        issue_c   = 1'b1;
        state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: if (bu_out_valid) state_nxt = S_NEXT;
      S_NEXT: begin
        sweep_done = (mot == MOT_LAST);
        state_nxt  = (mot == MOT_LAST) ? S_IDLE : S_CONV_H;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign adc.adc_start = start_c;
  assign adc.adc_chan  = {mot, side_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      per_cnt <= '0;
      to_cnt  <= '0;
      mot     <= '0;
      discard <= 1'b0;
      adc_err <= '0;
      pos_r   <= '0;
      vel_r   <= '0;
    end else begin
      state   <= state_nxt;
      per_cnt <= tick ? '0 : per_cnt + 1'b1;

      if (state == S_IDLE && tick && enable) mot <= '0;
      else if (state == S_NEXT && mot != MOT_LAST) mot <= mot + 1'b1;

      if (state == S_CONV_H || state == S_CONV_L) to_cnt <= '0;
      else if (waiting) to_cnt <= to_cnt + 1'b1;

      if (timeout) adc_err[mot] <= 1'b1;

      if (state == S_IDLE || state == S_NEXT) discard <= 1'b0;
      else if ((state == S_ISSUE || state == S_WAIT_RES) && bemf_clr[mot]) discard <= 1'b1;

      if (wb) begin
        pos_r <= set_mot(pos_r, bu_mot, bu_pos);
        vel_r <= set_mot(vel_r, bu_mot, bu_vel);
      end
      // Clears come last so they win over a coincident write-back or error.
      for (int n = 0; n < N_MOT; n++) begin
        if (bemf_clr[n]) begin
          pos_r[n]   <= '0;
          vel_r[n]   <= '0;
          adc_err[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WAIT_H && adc.adc_done) h_r <= adc.adc_data;
    if (state == S_WAIT_L && adc.adc_done) l_r <= adc.adc_data;
  end

  assign cur_pos = get_mot(pos_r, mot);
  assign cur_cal = get_mot(bemf_calib, mot);

  bemf_update #(
    .DATA_W(BEMF_W),
    .COEF_W(BEMF_W)
  ) u_bemf_update (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (issue_c),
    .bemf_adc_h    (h_r),
    .bemf_adc_l    (l_r),
    .mot_sel_in    (mot),
    .bemf_in       (cur_pos),
    .bemf_calib_in (cur_cal),
    .out_valid     (bu_out_valid),
    .mot_sel_out   (bu_mot),
    .bemf_out      (bu_pos),
    .bemf_vel_out  (bu_vel)
  );

  assign bemf_pos = pos_r;
  assign bemf_vel = vel_r;

endmodule
